// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN accelerator datapath.
// Bank selects, pooling modes and pool-engine FSM states.
package cnn_pkg;

    localparam int DATA_W_DEF = 20;

    localparam logic [2:0] SEL_SRC0 = 3'b001;
    localparam logic [2:0] SEL_DST0 = 3'b011;
    localparam logic [2:0] SEL_SRC1 = 3'b101;
    localparam logic [2:0] SEL_DST1 = 3'b111;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } pool_state_e;

endpackage

// File: rtl/pool_window_acc.sv
// 2x2 window accumulator: running signed max or widened sum,
// finalised (round, ReLU) into a registered result.
module pool_window_acc
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              fold,
    input  logic              last,
    input  pool_mode_e        mode,
    input  logic              relu_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] result
);

    localparam int SW = DATA_W + 2;

    logic signed [SW-1:0] acc_q, acc_d;
    logic signed [SW-1:0] din_x, folded, rounded;
    logic [DATA_W-1:0]    pooled, res_q, res_d;

    always_comb begin
        din_x = $signed({{2{din[DATA_W-1]}}, din});
        if (init) begin
            folded = din_x;
        end else if (mode == POOL_MAX) begin
            folded = (din_x > acc_q) ? din_x : acc_q;
        end else begin
            folded = acc_q + din_x;
        end
        // round-half-up average: (sum + 2) >>> 2
        rounded = folded + SW'(2);
        pooled  = (mode == POOL_MAX) ? folded[DATA_W-1:0]
                                     : rounded[DATA_W+1:2];
        acc_d = fold ? folded : acc_q;
        res_d = res_q;
        if (last) begin
            res_d = (relu_en && pooled[DATA_W-1]) ? '0 : pooled;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            res_q <= '0;
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end

    assign result = res_q;

endmodule

// File: rtl/cnn_pool_engine.sv
// 2x2 / stride-2 max or average pooling over one or two planes,
// read and written back through the csel-banked layer memory.
module cnn_pool_engine
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = 64,
    parameter int NUM_CH = 1,
    parameter int ADDR_W = 2 * $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic              pool_mode,
    input  logic              relu_en,
    output logic              busy,
    output logic              crd,
    output logic [ADDR_W-1:0] caddr_rd,
    input  logic [DATA_W-1:0] cdata_rd,
    output logic              cwr,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [DATA_W-1:0] cdata_wr,
    output logic [2:0]        csel
);

    localparam int   LW      = $clog2(IMG_W) - 1;
    localparam logic LAST_CH = 1'(NUM_CH - 1);

    pool_state_e       state_q, state_d;
    pool_mode_e        mode_q, mode_d;
    logic              relu_q, relu_d;
    logic              ch_q, ch_d;
    logic [LW-1:0]     oy_q, oy_d, ox_q, ox_d;
    logic [1:0]        k_q, k_d;
    logic              busy_q, busy_d, crd_q, crd_d, cwr_q, cwr_d;
    logic [ADDR_W-1:0] caddr_rd_q, caddr_rd_d;
    logic [ADDR_W-1:0] caddr_wr_q, caddr_wr_d;
    logic [2:0]        csel_q, csel_d;
    logic              acc_init, acc_fold, acc_last;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        relu_d  = relu_q;
        ch_d    = ch_q;
        oy_d    = oy_q;
        ox_d    = ox_q;
        k_d     = k_q;
        unique case (state_q)
            S_IDLE: begin
                if (ready) begin
                    state_d = S_RD;
                    mode_d  = pool_mode_e'(pool_mode);
                    relu_d  = relu_en;
                    ch_d    = 1'b0;
                    oy_d    = '0;
                    ox_d    = '0;
                    k_d     = '0;
                end
            end
            S_RD: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) state_d = S_WAIT;
            end
            S_WAIT: state_d = S_WR;
            S_WR: begin
                state_d = S_RD;
                ox_d    = ox_q + 1'b1;
                if (&ox_q) begin
                    oy_d = oy_q + 1'b1;
                    if (&oy_q) begin
                        if (ch_q == LAST_CH) state_d = S_DONE;
                        else ch_d = ~ch_q;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // strobes and addresses are registered from the next-state view
    always_comb begin
        busy_d     = (state_d == S_RD) || (state_d == S_WAIT)
                  || (state_d == S_WR);
        crd_d      = (state_d == S_RD);
        cwr_d      = (state_d == S_WR);
        caddr_rd_d = caddr_rd_q;
        caddr_wr_d = caddr_wr_q;
        csel_d     = csel_q;
        if (crd_d) begin
            caddr_rd_d = {oy_d, k_d[1], ox_d, k_d[0]};
            csel_d     = ch_d ? SEL_SRC1 : SEL_SRC0;
        end else if (cwr_d) begin
            caddr_wr_d = {2'b00, oy_d, ox_d};
            csel_d     = ch_d ? SEL_DST1 : SEL_DST0;
        end
    end

    // sample k arrives one cycle after its read
    assign acc_init = (state_q == S_RD) && (k_q == 2'd1);
    assign acc_fold = ((state_q == S_RD) && (k_q != 2'd0))
                   || (state_q == S_WAIT);
    assign acc_last = (state_q == S_WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            mode_q     <= POOL_MAX;
            relu_q     <= 1'b0;
            ch_q       <= 1'b0;
            oy_q       <= '0;
            ox_q       <= '0;
            k_q        <= '0;
            busy_q     <= 1'b0;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            caddr_rd_q <= '0;
            caddr_wr_q <= '0;
            csel_q     <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            relu_q     <= relu_d;
            ch_q       <= ch_d;
            oy_q       <= oy_d;
            ox_q       <= ox_d;
            k_q        <= k_d;
            busy_q     <= busy_d;
            crd_q      <= crd_d;
            cwr_q      <= cwr_d;
            caddr_rd_q <= caddr_rd_d;
            caddr_wr_q <= caddr_wr_d;
            csel_q     <= csel_d;
        end
    end

    pool_window_acc #(
        .DATA_W (DATA_W)
    ) u_acc (
        .clk     (clk),
        .reset   (reset),
        .init    (acc_init),
        .fold    (acc_fold),
        .last    (acc_last),
        .mode    (mode_q),
        .relu_en (relu_q),
        .din     (cdata_rd),
        .result  (cdata_wr)
    );

    assign busy     = busy_q;
    assign crd      = crd_q;
    assign cwr      = cwr_q;
    assign caddr_rd = caddr_rd_q;
    assign caddr_wr = caddr_wr_q;
    assign csel     = csel_q;

endmodule

// File: tb/tb_cnn_pool_engine.sv
// Bench for cnn_pool_engine: 8x8 planes, two channels, memory model
// on the csel-banked port, window results from a plain-arithmetic model.
module tb_cnn_pool_engine;

    localparam int DW   = 20;
    localparam int IMG  = 8;
    localparam int NCH  = 2;
    localparam int AW   = 6;
    localparam int OUTS = (IMG / 2) * (IMG / 2);
    localparam int RUNW = NCH * OUTS;

    typedef struct packed {
        logic [2:0]    sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ready = 1'b0;
    logic          pool_mode = 1'b0;
    logic          relu_en = 1'b0;
    logic          busy, crd, cwr;
    logic [AW-1:0] caddr_rd, caddr_wr;
    logic [DW-1:0] cdata_rd, cdata_wr;
    logic [2:0]    csel;

    logic [DW-1:0] mem [2][IMG*IMG];
    wr_t           wq[$];
    int            busy_total = 0;
    int            collide_total = 0;
    int            badsel_total = 0;
    logic          rd_pend = 1'b0;
    logic          rd_bank = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    int vectors = 0;
    int miscompares = 0;

    cnn_pool_engine #(
        .DATA_W (DW),
        .IMG_W  (IMG),
        .NUM_CH (NCH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ready    (ready),
        .pool_mode(pool_mode),
        .relu_en  (relu_en),
        .busy     (busy),
        .crd      (crd),
        .caddr_rd (caddr_rd),
        .cdata_rd (cdata_rd),
        .cwr      (cwr),
        .caddr_wr (caddr_wr),
        .cdata_wr (cdata_wr),
        .csel     (csel)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        rd_pend = crd;
        rd_bank = csel[2];
        rd_addr = caddr_rd;
        if (cwr) wq.push_back('{csel, caddr_wr, cdata_wr});
        if (crd && cwr) collide_total++;
        if (crd && csel[1:0] != 2'b01) badsel_total++;
        if (busy) busy_total++;
    end

    always @(posedge clk) begin
        if (rd_pend) cdata_rd <= mem[rd_bank][rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_pix(int b, int oy, int ox,
                                              bit mode, bit relu);
        int v[4];
        int r;
        for (int k = 0; k < 4; k++)
            v[k] = int'($signed(mem[b][(2*oy + k/2)*IMG + 2*ox + k%2]));
        if (!mode) begin
            r = v[0];
            for (int k = 1; k < 4; k++) if (v[k] > r) r = v[k];
        end else begin
            r = (v[0] + v[1] + v[2] + v[3] + 2) >>> 2;
        end
        if (relu && r < 0) r = 0;
        return r[DW-1:0];
    endfunction

    task automatic check_writes(input int base, input bit mode,
                                input bit relu);
        wr_t exp;
        int  i;
        for (int b = 0; b < NCH; b++)
            for (int oy = 0; oy < IMG/2; oy++)
                for (int ox = 0; ox < IMG/2; ox++) begin
                    i = b*OUTS + oy*(IMG/2) + ox;
                    exp.sel  = (b == 1) ? 3'b111 : 3'b011;
                    exp.addr = AW'(oy*(IMG/2) + ox);
                    exp.data = ref_pix(b, oy, ox, mode, relu);
                    chk($sformatf("wr%0d", i), 32'(wq[base+i]), 32'(exp));
                end
    endtask

    task automatic fill_random();
        logic [31:0] u;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < IMG*IMG; a++) begin
                u = $urandom;
                case ($urandom_range(0, 7))
                    0: mem[b][a] = 20'h7FFFF;
                    1: mem[b][a] = 20'h80000;
                    default: mem[b][a] = u[DW-1:0];
                endcase
            end
    endtask

    task automatic do_run(input bit mode, input bit relu, input bit pulse);
        int base = wq.size();
        int b0 = busy_total;
        int c0 = collide_total;
        int s0 = badsel_total;
        int cyc = 0;
        @(negedge clk);
        pool_mode = mode;
        relu_en   = relu;
        ready     = 1'b1;
        @(negedge clk);
        ready     = 1'b0;
        pool_mode = !mode;
        relu_en   = !relu;
        chk("busy_rise", 32'(busy), 32'd1);
        while (busy && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (pulse && cyc == 40) ready = 1'b1;
            if (pulse && cyc == 41) ready = 1'b0;
        end
        chk("run_end", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("busy_cycles", 32'(busy_total - b0), 32'(RUNW * 6));
        chk("collisions", 32'(collide_total - c0), 32'd0);
        chk("rd_sel", 32'(badsel_total - s0), 32'd0);
        chk("n_writes", 32'(wq.size() - base), 32'(RUNW));
        check_writes(base, mode, relu);
    endtask

    initial begin
        int base, nw, cyc, low, snap;

        #3 reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_crd", 32'(crd), 32'd0);
        chk("rst_cwr", 32'(cwr), 32'd0);
        chk("rst_caddr_rd", 32'(caddr_rd), 32'd0);
        chk("rst_caddr_wr", 32'(caddr_wr), 32'd0);
        chk("rst_cdata_wr", 32'(cdata_wr), 32'd0);
        chk("rst_csel", 32'(csel), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // ramp: max of each window is its bottom-right pixel
        for (int a = 0; a < IMG*IMG; a++) begin
            mem[0][a] = DW'(a);
            mem[1][a] = DW'(-a);
        end
        base = wq.size();
        do_run(1'b0, 1'b0, 1'b0);
        chk("ramp0", 32'(wq[base].data), 32'd9);
        chk("ramp1", 32'(wq[base+1].data), 32'd11);
        chk("ramp4", 32'(wq[base+4].data), 32'd25);

        // average with negatives and round-half-up
        fill_random();
        mem[0][0]  = 20'hFFFFF;
        mem[0][1]  = 20'hFFFFE;
        mem[0][8]  = 20'hFFFFD;
        mem[0][9]  = 20'hFFFFC;
        mem[0][2]  = 20'h00001;
        mem[0][3]  = 20'h00001;
        mem[0][10] = 20'h00001;
        mem[0][11] = 20'h00002;
        base = wq.size();
        do_run(1'b1, 1'b0, 1'b0);
        chk("avg_neg", 32'(wq[base].data), 32'h000FFFFE);
        chk("avg_round", 32'(wq[base+1].data), 32'd1);
        base = wq.size();
        do_run(1'b1, 1'b1, 1'b0);
        chk("avg_relu", 32'(wq[base].data), 32'd0);

        for (int r = 0; r < 4; r++) begin
            fill_random();
            do_run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   (r == 1));
        end

        // reset during the WR of output 10
        fill_random();
        @(negedge clk);
        pool_mode = 1'b1;
        relu_en   = 1'b0;
        ready     = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        nw  = 0;
        cyc = 0;
        while (nw < 11 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (cwr) nw++;
        end
        chk("reach_out10", 32'(nw), 32'd11);
        reset = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_cwr", 32'(cwr), 32'd0);
        chk("mid_crd", 32'(crd), 32'd0);
        chk("mid_cdata", 32'(cdata_wr), 32'd0);
        chk("mid_addr", 32'({caddr_rd, caddr_wr}), 32'd0);
        chk("mid_csel", 32'(csel), 32'd0);
        snap = wq.size();
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_wr_after_rst", 32'(wq.size()), 32'(snap));
        chk("idle_after_rst", 32'(busy), 32'd0);
        do_run(1'b1, 1'b0, 1'b0);

        // ready held high: back-to-back runs
        fill_random();
        base = wq.size();
        @(negedge clk);
        pool_mode = 1'b0;
        relu_en   = 1'b1;
        ready     = 1'b1;
        cyc = 0;
        while (!busy && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        cyc = 0;
        while (busy && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("held_end1", 32'(busy), 32'd0);
        low = 0;
        while (!busy && low < 10) begin
            low++;
            @(negedge clk);
        end
        ready = 1'b0;
        chk("held_gap", 32'(low), 32'd2);
        cyc = 0;
        while (busy && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("held_end2", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("held_writes", 32'(wq.size() - base), 32'(2 * RUNW));
        check_writes(base, 1'b0, 1'b1);
        check_writes(base + RUNW, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
